s_reg_reader: RTL and testbench
===============================

# s_reg_reader

Serial capture controller that sits directly downstream of the 8-bit parallel-in/serial-out shift register (`s_reg`). It drives that register's `shift_Nload` and `clk_inh` controls and samples its serial output `q_out`. It reassembles the word MSB-first and presents it on a parallel output with a valid/ready handshake. It replaces the testbench as the owner of the `s_reg` control pins in the integrated design.

## Interface
- `WIDTH`, default 8: number of bits per capture. Must equal the `s_reg` depth. Legal range is 2..16.
- `clk`  in  1: single rising-edge clock, shared with `s_reg`.
- `N_clr`  in  1: reset, asynchronous, active-low. Assertion is immediate; release is synchronous to `clk`.
- `start`  in  1: request one capture. Sampled only in IDLE.
- `q_h`  in  1: serial data from `s_reg.q_out`.
- `shift_Nload`  out  1: to `s_reg.shift_Nload`. 0 means parallel load, 1 means shift.
- `clk_inh`  out  1: to `s_reg.clk_inh`. 1 freezes `s_reg`.
- `data_out`  out  WIDTH: captured word. `data_out[WIDTH-1]` is the first bit received.
- `data_valid`  out  1: `data_out` holds a complete word.
- `data_ready`  in  1: the consumer accepts the word.
- `busy`  out  1: high in LOAD and SHIFT.

## Operation
- `s_reg` contract: on a rising `clk` with `clk_inh`=0, `s_reg` loads `par_in` if `shift_Nload`=0 and shifts toward `q_out` if `shift_Nload`=1. After a load, `q_out` = `par_in[7]`.
- The FSM has four states: IDLE, LOAD, SHIFT and VALID. All outputs are registered or a pure decode of state.
- IDLE: `clk_inh`=1, `shift_Nload`=1. If `start`=1, go to LOAD.
- LOAD: lasts one cycle. `clk_inh`=0, `shift_Nload`=0. Clear bit counter `cnt`. Go to SHIFT.
- SHIFT: `clk_inh`=0, `shift_Nload`=1.
  - On each edge, `sh <= {sh[WIDTH-2:0], q_h}` and `cnt <= cnt+1`.
  - When `cnt`==WIDTH-1, the final sample is taken, `data_out <= {sh[WIDTH-2:0], q_h}`, and the FSM goes to VALID.
  - `s_reg` shifts in the same edge it is sampled, so each sample sees the bit present before that shift.
- VALID: `clk_inh`=1, `data_valid`=1, `data_out` stable. When `data_ready`=1, go to IDLE and clear `data_valid` on the same edge.
- `cnt` is $clog2(WIDTH) bits wide and does not wrap within a capture.
- `start` outside IDLE is ignored; it is not queued.
- `data_ready` outside VALID is ignored.
- Reset values:
  - state = IDLE
  - `clk_inh`=1, `shift_Nload`=1
  - `data_out`=0, `data_valid`=0, `busy`=0
  - `cnt`=0, `sh`=0
- Reset mid-operation: the capture is abandoned immediately and `clk_inh` returns to 1 asynchronously. No partial word is ever flagged valid.

## Timing
- With `start` high at rising edge E in IDLE:
  - LOAD is active in cycle E..E+1.
  - `s_reg` loads at E+1.
  - Samples are taken at edges E+2 .. E+1+WIDTH.
  - `data_valid` rises after edge E+1+WIDTH. For WIDTH=8 that is 9 edges after E.
- Minimum capture period with `data_ready` tied high: WIDTH+3 cycles, i.e. 11 for WIDTH=8.
- The handshake completes on the edge where `data_valid` and `data_ready` are both high.
- `busy`=1 exactly for WIDTH+1 cycles per capture.

## Configuration
- `S_REG_READER_CONT_EN`
  - Defined:
    - `start` is ignored.
    - IDLE goes to LOAD unconditionally.
    - The VALID-to-IDLE transition on `data_ready` goes directly to LOAD instead.
    - Result is back-to-back captures every WIDTH+2 cycles while `data_ready`=1.
  - Undefined: captures occur only on `start`. This is the default.

## Test plan
- Pulse `start`, `par_in`=8'hA5, `data_ready`=1 -> `data_out`=8'hA5 and `data_valid` high 1 cycle, 9 edges after `start` edge. `busy` high 9 cycles.
- Run `par_in`=8'h80, then 8'h01 -> `data_out`=8'h80, then 8'h01. This confirms MSB-first order with no bit slip.
- Capture 8'h3C with `data_ready`=0 for 5 cycles -> `data_valid` and `data_out`=8'h3C held, `clk_inh`=1 throughout. The word is released on the `data_ready` edge, and `start` pulses during the stall are ignored.
- Assert `N_clr` low at the 4th SHIFT cycle -> all outputs take reset values immediately. The next `start` with 8'hFF yields exactly 8'hFF.
- With `S_REG_READER_CONT_EN` defined, `par_in` stepping 8'h11, 8'h22, 8'h33, `data_ready`=1 -> valid words 8'h11, 8'h22, 8'h33 spaced 10 cycles apart.

Source files
------------

// File: rtl/s_reg_reader.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : s_reg_reader                                                  |
// | Description : Drives the load/shift/inhibit pins of an s_reg PISO shifter,  |
// |               rebuilds its word MSB-first and hands it out over a           |
// |               valid/ready handshake. Macro S_REG_READER_CONT_EN enables     |
// |               free-running back-to-back captures.                           |
// | Revision    : 1.0  initial release                                          |
// +-----------------------------------------------------------------------------+
module s_reg_reader #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             N_clr,
  input  logic             start,
  input  logic             q_h,
  output logic             shift_Nload,
  output logic             clk_inh,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(WIDTH - 1);

`ifdef S_REG_READER_CONT_EN
  localparam logic c_cont_en = 1'b1;
`else
  localparam logic c_cont_en = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_VALID = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] w_sh_next;
  logic             w_go;

  // Each sample sees the bit s_reg presents before its own shift on this edge.
  assign w_sh_next = {r_sh[WIDTH-2:0], q_h};
  assign w_go      = c_cont_en || start;

  always_ff @(posedge clk or negedge N_clr) begin
    if (!N_clr) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_sh        <= '0;
      clk_inh     <= 1'b1;
      shift_Nload <= 1'b1;
      data_out    <= '0;
      data_valid  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_state     <= S_LOAD;
            r_cnt       <= '0;
            clk_inh     <= 1'b0;
            shift_Nload <= 1'b0;
            busy        <= 1'b1;
          end
        end

        S_LOAD: begin
          r_state     <= S_SHIFT;
          r_cnt       <= '0;
          shift_Nload <= 1'b1;
        end

        S_SHIFT: begin
          r_sh <= w_sh_next;
          if (r_cnt == c_cnt_last) begin
            // Last bit: freeze s_reg and publish the word on the same edge.
            r_state    <= S_VALID;
            data_out   <= w_sh_next;
            data_valid <= 1'b1;
            clk_inh    <= 1'b1;
            busy       <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_VALID: begin
          if (data_ready) begin
            data_valid <= 1'b0;
            if (c_cont_en) begin
              r_state     <= S_LOAD;
              r_cnt       <= '0;
              clk_inh     <= 1'b0;
              shift_Nload <= 1'b0;
              busy        <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end

        default: begin
          r_state     <= S_IDLE;
          clk_inh     <= 1'b1;
          shift_Nload <= 1'b1;
          data_valid  <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_s_reg_reader.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_s_reg_reader                                               |
// | Description : Bench for s_reg_reader with a behavioural 8-bit s_reg model.  |
// | Revision    : 1.0  initial release                                          |
// +-----------------------------------------------------------------------------+
module tb_s_reg_reader;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             N_clr;
  logic             start;
  logic             q_h;
  logic             shift_Nload;
  logic             clk_inh;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             data_ready;
  logic             busy;
  logic [7:0]       par_in;
  logic [7:0]       r_sreg = 8'h00;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] par;
    logic [7:0] exp_word;
  } vec_t;

  always #5 clk = ~clk;

  s_reg_reader #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .N_clr      (N_clr),
    .start      (start),
    .q_h        (q_h),
    .shift_Nload(shift_Nload),
    .clk_inh    (clk_inh),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .busy       (busy)
  );

  // Upstream parallel-in/serial-out register, MSB leaves first.
  always @(posedge clk) begin
    if (!clk_inh) begin
      if (!shift_Nload) r_sreg <= par_in;
      else              r_sreg <= {r_sreg[6:0], 1'b0};
    end
  end
  assign q_h = r_sreg[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_clk_inh"},     32'(clk_inh),     32'd1);
    check({tag, "_shift_Nload"}, 32'(shift_Nload), 32'd1);
    check({tag, "_data_out"},    32'(data_out),    32'd0);
    check({tag, "_data_valid"},  32'(data_valid),  32'd0);
    check({tag, "_busy"},        32'(busy),        32'd0);
  endtask

  // Pulse start at edge E; sample #1 after edges E..E+12 (index i = edge E+i).
  task automatic run_capture(input logic [7:0] par, output logic [7:0] word,
                             output int first_valid, output int busy_n, output int valid_n);
    @(negedge clk);
    par_in     = par;
    start      = 1'b1;
    data_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    first_valid = -1;
    busy_n      = 0;
    valid_n     = 0;
    word        = 8'h00;
    for (int i = 0; i < 13; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      if (busy) busy_n++;
      if (data_valid) begin
        valid_n++;
        if (first_valid < 0) begin
          first_valid = i;
          word        = data_out;
        end
      end
    end
  endtask

  initial begin
    vec_t       vecs[5];
    logic [7:0] word;
    int         fv, bn, vn;

    vecs[0] = '{par: 8'hA5, exp_word: 8'hA5};
    vecs[1] = '{par: 8'h80, exp_word: 8'h80};
    vecs[2] = '{par: 8'h01, exp_word: 8'h01};
    vecs[3] = '{par: 8'h5A, exp_word: 8'h5A};
    vecs[4] = '{par: 8'h00, exp_word: 8'h00};

    N_clr      = 1'b0;
    start      = 1'b0;
    data_ready = 1'b0;
    par_in     = 8'h11;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");

`ifdef S_REG_READER_CONT_EN
    begin
      logic [7:0] exp_words[3];
      int         n, last;
      exp_words[0] = 8'h11;
      exp_words[1] = 8'h22;
      exp_words[2] = 8'h33;
      n    = 0;
      last = -1;
      data_ready = 1'b1;
      @(negedge clk);
      N_clr = 1'b1;
      for (int cyc = 0; cyc < 60; cyc++) begin
        @(posedge clk);
        #1;
        if (data_valid && n < 3) begin
          check("cont_word", 32'(data_out), 32'(exp_words[n]));
          if (n > 0) check("cont_spacing", 32'(cyc - last), 32'd10);
          last = cyc;
          n++;
          if (n == 1) par_in = 8'h22;
          else        par_in = 8'h33;
        end
      end
      check("cont_word_count", 32'(n), 32'd3);
    end
`else
    @(negedge clk);
    N_clr = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    for (int v = 0; v < 5; v++) begin
      run_capture(vecs[v].par, word, fv, bn, vn);
      check("vec_word",        32'(word), 32'(vecs[v].exp_word));
      check("vec_valid_edge",  32'(fv),   32'd9);
      check("vec_busy_cycles", 32'(bn),   32'd9);
      check("vec_valid_cycles",32'(vn),   32'd1);
    end

    // Consumer stall: word must be held with s_reg frozen, start ignored.
    @(negedge clk);
    par_in     = 8'h3C;
    start      = 1'b1;
    data_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    fv = 0;
    for (int i = 0; i < 20 && !data_valid; i++) @(negedge clk);
    check("stall_reach_valid", 32'(data_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid",   32'(data_valid), 32'd1);
      check("stall_data",    32'(data_out),   32'h3C);
      check("stall_clk_inh", 32'(clk_inh),    32'd1);
      start = ~start;
      @(negedge clk);
    end
    start      = 1'b0;
    data_ready = 1'b1;
    @(negedge clk);
    check("release_valid", 32'(data_valid), 32'd0);
    check("release_busy",  32'(busy),       32'd0);
    @(negedge clk);
    check("no_queued_start", 32'(busy), 32'd0);

    // Reset in the 4th SHIFT cycle of a capture.
    @(negedge clk);
    par_in = 8'h5A;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 N_clr = 1'b0;
    #1 check_reset_outputs("midreset");
    @(negedge clk);
    N_clr = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_valid",   32'(data_valid), 32'd0);
    check("post_reset_clk_inh", 32'(clk_inh),    32'd1);
    run_capture(8'hFF, word, fv, bn, vn);
    check("after_reset_word",       32'(word), 32'hFF);
    check("after_reset_valid_edge", 32'(fv),   32'd9);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
